// File: rtl/imm_pkg.sv
// Shared types for the registered immediate generator.
// Holds the imm_src encodings, the pipeline entry struct and the FSM states.
package imm_pkg;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I    = 3'b000;
    localparam imm_src_t IMM_S    = 3'b001;
    localparam imm_src_t IMM_B    = 3'b010;
    localparam imm_src_t IMM_J    = 3'b011;
    localparam imm_src_t IMM_JALR = 3'b100;
    localparam imm_src_t IMM_U    = 3'b101;
    localparam imm_src_t IMM_Z    = 3'b110;

    // Entry fields are sized for the widest legal XLEN; narrower builds
    // zero-fill the upper bits and ignore them on the way out.
    localparam int unsigned IMM_MAX_W = 64;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [IMM_MAX_W-1:0] target;
        imm_src_t             src;
    } imm_entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate extraction and sign extension.
// Ports: instr[31:7], imm_src -> imm (XLEN). Macro IMM_GEN_ZICSR_EN adds zimm.
import imm_pkg::*;

module imm_decode #(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr,
    input  imm_src_t        imm_src,
    output logic [XLEN-1:0] imm
);

    // Re-index so bit numbers match the architectural instruction word.
    logic [31:7]        w_i;
    logic signed [31:0] w_s;

    assign w_i = instr;

    always_comb begin
        w_s = {{20{w_i[31]}}, w_i[31:20]};
        case (imm_src)
            IMM_S: w_s = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
            IMM_B: w_s = {{19{w_i[31]}}, w_i[31], w_i[7],
                          w_i[30:25], w_i[11:8], 1'b0};
            IMM_J: w_s = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                          w_i[20], w_i[30:21], 1'b0};
            IMM_U: w_s = {w_i[31:12], 12'b0};
            default: w_s = {{20{w_i[31]}}, w_i[31:20]};
        endcase
        // Signed cast widens from bit 31 when XLEN=64.
        imm = XLEN'(w_s);
`ifdef IMM_GEN_ZICSR_EN
        if (imm_src == IMM_Z) begin
            imm = XLEN'(w_i[19:15]);
        end
`endif
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with pc-relative target and 2-entry skid.
// Ports: clk, rst, flush, in_valid/in_ready, instr, imm_src, pc,
// out_valid/out_ready, imm_ext, target, out_src. Macro: IMM_GEN_ZICSR_EN.
import imm_pkg::*;

module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    input  logic [PC_W-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [PC_W-1:0] target,
    output logic [2:0]      out_src
);

    logic [XLEN-1:0] w_imm;
    logic [PC_W-1:0] w_tgt;
    imm_entry_t      w_new;
    imm_entry_t      r_m;
    imm_entry_t      r_k;
    pipe_state_t     r_state;
    pipe_state_t     w_state_nxt;
    logic            w_accept;
    logic            w_drain;
    logic            w_load_m_new;
    logic            w_load_m_k;
    logic            w_load_k;
    logic            w_unused;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (instr),
        .imm_src (imm_src),
        .imm     (w_imm)
    );

    assign w_tgt = pc + w_imm[PC_W-1:0];

    always_comb begin
        w_new        = '0;
        w_new.imm    = IMM_MAX_W'(w_imm);
        w_new.target = IMM_MAX_W'(w_tgt);
        w_new.src    = imm_src;
    end

    // Both valid bits are implied by the state register.
    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = (r_state != ST_FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_drain   = out_valid && out_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_load_m_new = 1'b0;
        w_load_m_k   = 1'b0;
        w_load_k     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = ST_ONE;
                    w_load_m_new = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_drain) begin
                    w_load_m_new = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_k    = 1'b1;
                end else if (w_drain) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_drain) begin
                    w_state_nxt = ST_ONE;
                    w_load_m_k  = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        // Kill beats any load; stale data stays but is never marked valid.
        if (flush) begin
            w_state_nxt  = ST_EMPTY;
            w_load_m_new = 1'b0;
            w_load_m_k   = 1'b0;
            w_load_k     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
            r_k <= '0;
        end else begin
            if (w_load_m_new) begin
                r_m <= w_new;
            end else if (w_load_m_k) begin
                r_m <= r_k;
            end
            if (w_load_k) begin
                r_k <= w_new;
            end
        end
    end

    assign imm_ext = r_m.imm[XLEN-1:0];
    assign target  = r_m.target[PC_W-1:0];
    assign out_src = r_m.src;

    // Upper entry bits are dead when XLEN or PC_W is below 64.
    assign w_unused = ^r_m;

endmodule
